syscall_print_ctrl: RTL

Sequencer for the print-string syscall. On a syscall strobe it walks a NUL-terminated string in data memory starting at byte address a0, fetching whole words through a req/ack read port. It emits one character per valid/ready handshake to the console sink and asserts busy so the pipeline stalls until the string is fully printed. It replaces the untimed string loop with a synthesizable, cycle-accurate controller.

---
 rtl/syscall_print_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/syscall_print_ctrl.sv
// syscall_print_ctrl: print-string syscall sequencer.
// Walks a NUL-terminated string in memory starting at str_addr. Each word is
// fetched once over a req/ack port, and one character is emitted per
// valid/ready handshake. busy stalls the pipeline until done pulses. A string
// that reaches MAX_LEN characters is cut short, and overflow pulses with done.
module syscall_print_ctrl #(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] str_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       sel_s;
  logic [31:0]      addr_inc_s;
  logic             emit_ok_s;

  // Little-endian byte lane select: offset 0 is bits [7:0].
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Current byte, next address and whether the current byte may be emitted.
  always_comb begin
    sel_s      = pick_byte(word_q, addr_q[1:0]);
    addr_inc_s = addr_q + 32'd1;
    emit_ok_s  = (sel_s != 8'h00) && (cnt_q != MAX_CNT);
  end

  // Next-state logic for the string walk.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = str_addr;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          word_d  = mem_rdata;
          state_d = ST_EMIT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EMIT: begin
        if (sel_s == 8'h00) begin
          state_d = ST_DONE;
        end else if (cnt_q == MAX_CNT) begin
          // Non-NUL byte past the limit: the string is truncated here.
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else if (char_ready) begin
          addr_d = addr_inc_s;
          cnt_d  = cnt_q + CNT_W'(1);
          if (addr_inc_s[1:0] == 2'b00) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_EMIT;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode only registered state, so they carry no input-to-output path.
  always_comb begin
    mem_req    = (state_q == ST_FETCH);
    mem_addr   = {addr_q[31:2], 2'b00};
    char_valid = (state_q == ST_EMIT) && emit_ok_s;
    if ((state_q == ST_EMIT) && emit_ok_s) begin
      char_data = sel_s;
    end else begin
      char_data = 8'h00;
    end
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    overflow = (state_q == ST_DONE) && ovf_q;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0000_0000;
      word_q  <= 32'h0000_0000;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
